// File: rtl/uop_queue.sv
// ============================================================================
// Module   : uop_queue
// Purpose  : Queue of fetched instruction pairs between fetch and decode.
//            The FIFO holds up to DEPTH pairs behind a registered output
//            stage. A pair is pushed when prev_valid=1 and stalled=0, and
//            popped when valid=1 and next_stalled=0. The clear input flushes
//            the queue. The reset input has priority over everything else.
// Config   : UOP_QUEUE_BYPASS_EN - when defined, a pair pushed into an empty
//            queue goes straight into a loadable output register. This gives
//            1-cycle latency instead of 2.
// Ports    : clk, reset (sync, active-high), clear (flush)
//            prev_valid, instruction_1, instruction_2   - upstream pair
//            stalled                                    - upstream back-pressure
//            next_stalled                               - downstream back-pressure
//            valid, out_instruction_1, out_instruction_2 - output pair
//            count                                      - pairs held in FIFO
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uop_queue_pkg;
  typedef struct packed {
    logic [31:0] instruction;
    logic [3:0]  branch_tag;
  } fetched_instruction;
endpackage

module uop_queue
  import uop_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     prev_valid,
  input  fetched_instruction       instruction_1,
  input  fetched_instruction       instruction_2,
  output logic                     stalled,
  input  logic                     next_stalled,
  output logic                     valid,
  output fetched_instruction       out_instruction_1,
  output fetched_instruction       out_instruction_2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int              AW         = $clog2(DEPTH);
  localparam int              CW         = AW + 1;
  localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);

  fetched_instruction mem_1 [DEPTH];
  fetched_instruction mem_2 [DEPTH];

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  logic push;
  logic pop;
  logic loadable;
  logic fifo_rd;
  logic fifo_wr;
  logic bypass;

  assign stalled  = (count == FULL_COUNT);
  assign push     = prev_valid & ~stalled;
  assign pop      = valid & ~next_stalled;
  // The output register can take a new pair when it is empty or being drained.
  assign loadable = ~valid | pop;
  assign fifo_rd  = loadable & (count != '0);

`ifdef UOP_QUEUE_BYPASS_EN
  // An empty FIFO with a loadable output lets the incoming pair skip storage.
  assign bypass = loadable & (count == '0) & push;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_wr = push & ~bypass;

  // Control state: pointers, occupancy and output valid
  always_ff @(posedge clk) begin
    if (reset) begin
      valid  <= 1'b0;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (clear) begin
      valid  <= 1'b0;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      // Power-of-two depth: pointers wrap naturally at their width.
      if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;

      case ({fifo_wr, fifo_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (loadable) valid <= fifo_rd | bypass;
    end
  end

  // Datapath: storage and output register are left uninitialised. Their
  // contents only matter when qualified by count/valid. While count is
  // non-zero and below DEPTH, the read and write slots are always distinct.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      mem_1[wr_ptr] <= instruction_1;
      mem_2[wr_ptr] <= instruction_2;
    end
    if (fifo_rd) begin
      out_instruction_1 <= mem_1[rd_ptr];
      out_instruction_2 <= mem_2[rd_ptr];
    end else if (bypass) begin
      out_instruction_1 <= instruction_1;
      out_instruction_2 <= instruction_2;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uop_queue.sv
// ============================================================================
// Module   : tb_uop_queue
// Purpose  : Self-checking bench for uop_queue.
//            The reference model tracks the pairs in flight with a queue and
//            an occupancy count. A monitor pops the expected pairs as the DUT
//            presents them. Directed scenarios are followed by a random phase.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uop_queue;
  import uop_queue_pkg::*;

  localparam int DEPTH = 4;
`ifdef UOP_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    fetched_instruction i1;
    fetched_instruction i2;
  } pair_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 clear;
  logic                 prev_valid;
  logic                 next_stalled;
  logic                 stalled;
  logic                 valid;
  fetched_instruction   instruction_1;
  fetched_instruction   instruction_2;
  fetched_instruction   out_instruction_1;
  fetched_instruction   out_instruction_2;
  logic [$clog2(DEPTH):0] count;

  int    checks = 0;
  int    errors = 0;
  pair_t exp_q[$];
  pair_t exp_pair;
  int    m_inflight = 0;   // pairs accepted and not yet popped (incl. output)
  bit    m_valid    = 1'b0;
  bit    chk_en     = 1'b0;
  int    m_stored;
  bit    m_push;
  bit    m_pop;
  int    lat;

  localparam fetched_instruction A1 = '{instruction: 32'h11111111, branch_tag: 4'd1};
  localparam fetched_instruction A2 = '{instruction: 32'h22222222, branch_tag: 4'd2};

  uop_queue #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset             (reset),
    .clear             (clear),
    .prev_valid        (prev_valid),
    .instruction_1     (instruction_1),
    .instruction_2     (instruction_2),
    .stalled           (stalled),
    .next_stalled      (next_stalled),
    .valid             (valid),
    .out_instruction_1 (out_instruction_1),
    .out_instruction_2 (out_instruction_2),
    .count             (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: applies the queue rules to the inputs seen at each edge.
  initial forever begin
    @(posedge clk);
    if (reset || clear) begin
      exp_q.delete();
      m_inflight = 0;
      m_valid    = 1'b0;
      if (reset) chk_en = 1'b1;
    end else if (chk_en) begin
      m_stored = m_inflight - int'(m_valid);
      m_push   = prev_valid && (m_stored != DEPTH);
      m_pop    = m_valid && !next_stalled;
      if (m_push) begin
        exp_q.push_back({instruction_1, instruction_2});
        m_inflight++;
      end
      if (m_pop) m_inflight--;
      if (!m_valid || m_pop) m_valid = (m_stored > 0) || (BYP && m_push);
    end
  end

  // Monitor: checks status every cycle and scores each pair the DUT hands off.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("valid",   valid,   m_valid);
      chk("count",   count,   m_inflight - int'(m_valid));
      chk("stalled", stalled, (m_inflight - int'(m_valid)) == DEPTH);
      if (valid && !next_stalled) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pair actual=%0h required=none",
                   {out_instruction_1, out_instruction_2});
        end else begin
          exp_pair = exp_q.pop_front();
          chk("out_pair", {out_instruction_1, out_instruction_2}, exp_pair);
        end
      end
    end
  end

  task automatic apply(input bit p, input bit n, input bit c, input bit r,
                       input fetched_instruction a, input fetched_instruction b);
    prev_valid    = p;
    next_stalled  = n;
    clear         = c;
    reset         = r;
    instruction_1 = a;
    instruction_2 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit p, input bit n, input bit c, input bit r);
    fetched_instruction a;
    fetched_instruction b;
    a = '{instruction: $urandom(), branch_tag: 4'($urandom())};
    b = '{instruction: $urandom(), branch_tag: 4'($urandom())};
    apply(p, n, c, r, a, b);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; prev_valid = 1'b0; next_stalled = 1'b0;
    instruction_1 = '0; instruction_2 = '0;
    @(posedge clk); #1;
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("reset_valid",   valid,   0);
    chk("reset_count",   count,   0);
    chk("reset_stalled", stalled, 0);

    // Single pair A: latency, contents, drain
    apply(1, 0, 0, 0, A1, A2);
    lat = 1;
    while (!valid && lat < 8) begin
      step(0, 0, 0, 0);
      lat++;
    end
    chk("a_latency", lat, BYP ? 1 : 2);
    chk("a_out1", out_instruction_1, A1);
    chk("a_out2", out_instruction_2, A2);
    step(0, 0, 0, 0);
    chk("a_count_after", count, 0);
    chk("a_valid_after", valid, 0);

    // Fill under back-pressure; the last push must be refused
    repeat (6) step(1, 1, 0, 0);
    chk("fill_count",   count,   DEPTH);
    chk("fill_stalled", stalled, 1);

    // Release for one cycle: exactly one pop
    step(0, 0, 0, 0);
    chk("release_count",   count,   DEPTH - 1);
    chk("release_stalled", stalled, 0);
    step(0, 1, 0, 0);
    chk("hold_count", count, DEPTH - 1);

    // Stream with toggling back-pressure across pointer wrap
    for (int i = 0; i < 20; i++) step(1, (i % 2) == 0, 0, 0);
    repeat (12) step(0, 0, 0, 0);
    chk("stream_drained_valid", valid, 0);
    chk("stream_drained_count", count, 0);

    // Clear with count=3, valid=1 and a pair offered
    repeat (4) step(1, 1, 0, 0);
    chk("pre_clear_valid", valid, 1);
    chk("pre_clear_count", count, 3);
    step(1, 0, 1, 0);
    chk("clear_valid",   valid,   0);
    chk("clear_count",   count,   0);
    chk("clear_stalled", stalled, 0);
    repeat (4) step(0, 0, 0, 0);
    chk("post_clear_valid", valid, 0);

    // Reset and clear together with count=2
    repeat (3) step(1, 1, 0, 0);
    chk("pre_rc_count", count, 2);
    step(1, 0, 1, 1);
    chk("rc_valid", valid, 0);
    chk("rc_count", count, 0);

    // Random traffic with occasional flushes and resets
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 39) == 0, $urandom_range(0, 79) == 0);
    repeat (12) step(0, 0, 0, 0);
    chk("final_valid", valid, 0);
    chk("final_count", count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
